// File: rtl/dircc_node_mem_reader.sv
// Purpose : Avalon-MM read master on a node memory's 16-bit s2 port; streams a
//           (base, length) burst of halfwords out as one Avalon-ST packet.
// Latency : first beat 3 cycles after command accept, then 1 beat/cycle; done 1 cycle after eop.
// Backpr. : st_ready low stalls issue once buffered + in-flight reads reach FIFO_DEPTH.
//
// Optional feature: define DIRCC_MEM_READER_STATS_EN to count backpressure cycles
// on stall_cycles; otherwise stall_cycles is tied to 0.
//
// Ports:
//   clk, reset_n                     clock (shared with memory), async active-low reset
//   cmd_valid/cmd_ready/addr/len     command handshake: first halfword address, halfword count
//   mem_*                            s2 read master; readdata valid the cycle after chipselect
//   st_valid/ready/data/sop/eop      output packet stream
//   busy, done, stall_cycles         status: command active, completion pulse, stall counter

// Small generic synchronous FIFO with a combinational head (show-ahead) read.
// Latency: 1 cycle write-to-read. Backpressure: writer must respect count; a
// write into a full FIFO is flagged by assertion.
module dircc_node_mem_reader_fifo #(
  parameter  int W     = 16,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_vld,
  input  logic [W-1:0]     wr_dat,
  input  logic             rd_rdy,
  output logic             rd_vld,
  output logic [W-1:0]     rd_dat,
  output logic [CNT_W-1:0] count
);
  logic [W-1:0]     store [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             pop;

  assign rd_vld = (count != '0);
  assign pop    = rd_vld && rd_rdy;
  assign rd_dat = store[rd_ptr];

  // Storage is reset so the head (and thus st_data) reads 0 out of reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) store[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_vld) begin
        store[wr_ptr] <= wr_dat;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_vld, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(wr_vld && (count == CNT_W'(DEPTH))));
endmodule

module dircc_node_mem_reader #(
  parameter int ADDR_W     = 15,
  parameter int MEM_WORDS  = 20480,
  parameter int LEN_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [1:0]        mem_byteenable,
  output logic              mem_clken,
  input  logic [15:0]       mem_readdata,
  output logic              st_valid,
  input  logic              st_ready,
  output logic [15:0]       st_data,
  output logic              st_sop,
  output logic              st_eop,
  output logic              busy,
  output logic              done,
  output logic [31:0]       stall_cycles
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t             state;
  logic [ADDR_W-1:0]  cur;
  logic [ADDR_W-1:0]  cur_nxt;
  logic [LEN_W-1:0]   remaining;   // reads still to issue
  logic [LEN_W-1:0]   beats_left;  // beats still to hand downstream
  logic               first_sent;  // first beat of this command already accepted
  logic               inflight;    // a read was issued last cycle; data lands now
  logic [CNT_W-1:0]   fifo_count;
  logic [CNT_W-1:0]   credit;
  logic               issue;
  logic               accept;
  logic               beat;

  assign mem_write      = 1'b0;
  assign mem_byteenable = 2'b11;
  assign mem_clken      = 1'b1;

  // Credit uses the registered occupancy only, so a beat accepted this cycle
  // frees its slot for issue on the following cycle.
  assign credit  = fifo_count + CNT_W'(inflight);
  assign issue   = (state == ISSUE) && (credit < CNT_W'(FIFO_DEPTH));
  assign accept  = cmd_valid && cmd_ready;
  assign beat    = st_valid && st_ready;
  assign cur_nxt = (cur == ADDR_W'(MEM_WORDS - 1)) ? '0 : cur + 1'b1;

  assign mem_chipselect = issue;
  assign mem_address    = cur;
  assign busy           = (state != IDLE);
  assign st_sop         = st_valid && !first_sent;
  assign st_eop         = st_valid && (beats_left == LEN_W'(1));

  dircc_node_mem_reader_fifo #(.W(16), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_vld  (inflight),
    .wr_dat  (mem_readdata),
    .rd_rdy  (st_ready),
    .rd_vld  (st_valid),
    .rd_dat  (st_data),
    .count   (fifo_count)
  );

  // cmd_ready is a register so it stays low through reset and the done cycle,
  // rising on the edge after either.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cmd_ready  <= 1'b0;
      done       <= 1'b0;
      cur        <= '0;
      remaining  <= '0;
      beats_left <= '0;
      first_sent <= 1'b0;
      inflight   <= 1'b0;
    end else begin
      inflight <= issue;
      done     <= 1'b0;
      if (beat) begin
        first_sent <= 1'b1;
        beats_left <= beats_left - 1'b1;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            cmd_ready  <= 1'b0;
            cur        <= cmd_addr;
            remaining  <= cmd_len;
            beats_left <= cmd_len;
            first_sent <= 1'b0;
            if (cmd_len == '0) done  <= 1'b1;
            else               state <= ISSUE;
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        ISSUE: begin
          if (issue) begin
            cur       <= cur_nxt;
            remaining <= remaining - 1'b1;
            if (remaining == LEN_W'(1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (beat && st_eop) begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DIRCC_MEM_READER_STATS_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                     stall_q <= '0;
    else if (accept)                                  stall_q <= '0;
    else if (st_valid && !st_ready && stall_q != '1)  stall_q <= stall_q + 1'b1;
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif
endmodule

// File: tb/tb_dircc_node_mem_reader.sv
// Bench for dircc_node_mem_reader: behavioural s2 memory, scoreboard of
// expected beats/addresses filled on command accept and drained on output.
module tb_dircc_node_mem_reader;
  localparam int ADDR_W     = 15;
  localparam int MEM_WORDS  = 20480;
  localparam int LEN_W      = 16;
  localparam int FIFO_DEPTH = 4;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_chipselect;
  logic              mem_write;
  logic [1:0]        mem_byteenable;
  logic              mem_clken;
  logic [15:0]       mem_readdata = 16'h0;
  logic              st_valid;
  logic              st_ready;
  logic [15:0]       st_data;
  logic              st_sop;
  logic              st_eop;
  logic              busy;
  logic              done;
  logic [31:0]       stall_cycles;

  dircc_node_mem_reader #(
    .ADDR_W(ADDR_W), .MEM_WORDS(MEM_WORDS), .LEN_W(LEN_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .mem_address(mem_address), .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_byteenable(mem_byteenable), .mem_clken(mem_clken), .mem_readdata(mem_readdata),
    .st_valid(st_valid), .st_ready(st_ready), .st_data(st_data), .st_sop(st_sop),
    .st_eop(st_eop), .busy(busy), .done(done), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  logic [15:0] tbmem [MEM_WORDS];
  always @(posedge clk) mem_readdata <= tbmem[mem_address];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Scoreboard state
  logic [17:0] exp_q[$];   // {sop, eop, data}
  int          addr_q[$];
  int acc_cnt = 0, acc_cyc = 0, done_cnt = 0, done_cyc = 0, eop_cyc = 0, first_cyc = 0;
  int beat_cnt = 0, vld_cnt = 0, cs_cnt = 0;
  bit want_first = 0, done_prev = 0, hold_pend = 0;
  logic [15:0] hold_dat = 16'h0;
  int mon_a;
  bit tog_mode = 0;

  always @(negedge clk) begin
    if (cmd_valid && cmd_ready) begin
      acc_cnt++;
      acc_cyc    = cyc;
      want_first = 1;
      mon_a      = int'(cmd_addr);
      for (int i = 0; i < int'(cmd_len); i++) begin
        exp_q.push_back({(i == 0), (i == int'(cmd_len) - 1), tbmem[mon_a]});
        addr_q.push_back(mon_a);
        mon_a = (mon_a == MEM_WORDS - 1) ? 0 : mon_a + 1;
      end
    end
    if (mem_chipselect) begin
      cs_cnt++;
      if (addr_q.size() == 0) chk("addr_unexp", 32'(mem_address), 32'hFFFF_FFFF);
      else                    chk("addr", 32'(mem_address), 32'(addr_q.pop_front()));
    end
    if (hold_pend && st_valid) chk("hold_data", 32'(st_data), 32'(hold_dat));
    hold_pend = st_valid && !st_ready;
    hold_dat  = st_data;
    if (st_valid) begin
      vld_cnt++;
      if (want_first) begin
        first_cyc  = cyc;
        want_first = 0;
      end
    end
    if (st_valid && st_ready) begin
      beat_cnt++;
      if (exp_q.size() == 0) chk("beat_unexp", 32'({st_sop, st_eop, st_data}), 32'h3FFFF);
      else                   chk("beat", 32'({st_sop, st_eop, st_data}), 32'(exp_q.pop_front()));
      if (st_eop) eop_cyc = cyc;
    end
    if (done_prev) chk("rdy_after_done", 32'(cmd_ready), 1);
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      chk("done_rdy", 32'(cmd_ready), 0);
      chk("done_busy", 32'(busy), 0);
    end
    done_prev = done;
  end

  // st_ready: held high, or toggled every cycle when tog_mode is set.
  initial begin
    st_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      st_ready = tog_mode ? ~st_ready : 1'b1;
    end
  end

  task automatic send_cmd(input int a, input int l);
    int n = 0;
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_addr  = ADDR_W'(a);
    cmd_len   = LEN_W'(l);
    while (!cmd_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("cmd_accept", 32'(cmd_ready), 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int d0 = done_cnt;
    int n  = 0;
    while (done_cnt == d0 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    chk(tag, 32'(done_cnt - d0), 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 0);
    chk({tag, "_busy"},      32'(busy), 0);
    chk({tag, "_done"},      32'(done), 0);
    chk({tag, "_st_valid"},  32'(st_valid), 0);
    chk({tag, "_sop_eop"},   32'({st_sop, st_eop}), 0);
    chk({tag, "_cs"},        32'(mem_chipselect), 0);
    chk({tag, "_addr"},      32'(mem_address), 0);
    chk({tag, "_st_data"},   32'(st_data), 0);
    chk({tag, "_stall"},     stall_cycles, 0);
    chk({tag, "_consts"},    32'({mem_write, mem_byteenable, mem_clken}), 32'b0111);
  endtask

  int a0, d0, b0, c0, v0, n;

  initial begin
    for (int i = 0; i < MEM_WORDS; i++) tbmem[i] = 16'(i) ^ 16'h5A5A;
    for (int i = 0; i < 4; i++) tbmem[256 + i] = 16'hA0A0 + 16'(i);
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    reset_n   = 1'b0;

    // Reset state and first ready after release
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("rst");
    reset_n = 1'b1;
    #1;
    chk("rdy_before_edge", 32'(cmd_ready), 0);
    @(posedge clk); #1;
    chk("rdy_after_reset", 32'(cmd_ready), 1);

    // Basic packet, timing relative to accept
    send_cmd(32'h100, 4);
    chk("busy_active", 32'(busy), 1);
    wait_done("done_a");
    chk("first_valid_lat", 32'(first_cyc - acc_cyc), 3);
    chk("done_lat", 32'(done_cyc - acc_cyc), 7);
    chk("done_after_eop", 32'(done_cyc - eop_cyc), 1);

    // Address wrap at end of memory
    send_cmd(20478, 4);
    wait_done("done_wrap");
    chk("wrap_done_lat", 32'(done_cyc - acc_cyc), 7);

    // Toggling backpressure
    tog_mode = 1;
    send_cmd(32'h40, 16);
    wait_done("done_toggle");
    tog_mode = 0;
    chk("toggle_left", 32'(exp_q.size()), 0);
`ifdef DIRCC_MEM_READER_STATS_EN
    chk("stall_cnt", 32'((stall_cycles == 32'd15) || (stall_cycles == 32'd16)), 1);
`else
    chk("stall_cnt", stall_cycles, 0);
`endif

    // Zero-length command
    c0 = cs_cnt;
    v0 = vld_cnt;
    send_cmd(32'h10, 0);
    wait_done("done_len0");
    chk("len0_done_lat", 32'(done_cyc - acc_cyc), 1);
    chk("len0_no_cs", 32'(cs_cnt - c0), 0);
    chk("len0_no_valid", 32'(vld_cnt - v0), 0);
    chk("stall_cleared", stall_cycles, 0);

    // Reset in the middle of a packet
    d0 = done_cnt;
    b0 = beat_cnt;
    send_cmd(32'h500, 10);
    n = 0;
    while (beat_cnt < b0 + 2 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("beat3_reached", 32'(beat_cnt - b0), 2);
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    exp_q.delete();
    addr_q.delete();
    want_first = 0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_rdy", 32'(cmd_ready), 1);
    chk("midrst_no_done", 32'(done_cnt - d0), 0);
    send_cmd(32'h600, 2);
    wait_done("done_after_rst");
    chk("after_rst_left", 32'(exp_q.size()), 0);

    // cmd_valid held high with changing address: one accept per done
    a0 = acc_cnt;
    d0 = done_cnt;
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_addr  = ADDR_W'(32'h300);
    cmd_len   = LEN_W'(8);
    n = 0;
    while (done_cnt == d0 && n < 500) begin
      @(posedge clk); #1;
      cmd_addr = cmd_addr + ADDR_W'(7);
      n++;
    end
    chk("hold_one_accept", 32'(acc_cnt - a0), 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("hold_second_accept", 32'(acc_cnt - a0), 2);
    chk("hold_accept_after_done", 32'(acc_cyc - done_cyc), 1);
    wait_done("done_hold2");

    repeat (3) @(posedge clk);
    #1;
    chk("final_beats_left", 32'(exp_q.size()), 0);
    chk("final_addrs_left", 32'(addr_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dircc_node_mem_reader.md
# dircc_node_mem_reader

Avalon-MM read master paired with the 16-bit second port (s2) of a node's dual-port processing memory. It converts a command (base halfword address, length) into a pipelined burst of single-cycle reads and emits the returned data as an Avalon-ST packet with valid/ready backpressure. The node's soft processor writes messages through the 32-bit port. This block drains them toward the node's network/mailbox path without processor involvement.

## Interface
- ADDR_W, 15: halfword address width of the memory port.
- MEM_WORDS, 20480: memory depth in halfwords; addresses wrap modulo this value.
- LEN_W, 16: width of the command length field.
- FIFO_DEPTH, 4: return-data buffer depth; power of two, minimum 2.

- clk  in  1  single clock, shared with the memory.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block idle and accepting a command.
- cmd_addr  in  ADDR_W  first halfword address; must be < MEM_WORDS.
- cmd_len  in  LEN_W  number of halfwords to read; 0 is legal.
- mem_address  out  ADDR_W  to s2 address.
- mem_chipselect  out  1  read issue strobe.
- mem_write  out  1  constant 0.
- mem_byteenable  out  2  constant 2'b11.
- mem_clken  out  1  constant 1.
- mem_readdata  in  16  s2 read data, valid the cycle after issue.
- st_valid  out  1  stream beat valid.
- st_ready  in  1  downstream accepts beat.
- st_data  out  16  halfword.
- st_sop  out  1  first beat of packet.
- st_eop  out  1  last beat of packet.
- busy  out  1  command in progress.
- done  out  1  one-cycle pulse when the packet is fully accepted downstream.
- stall_cycles  out  32  backpressure counter (see Configuration).

## Operation
- States: IDLE, ISSUE, DRAIN.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready, latch cur=cmd_addr, remaining=cmd_len, and clear the first-beat flag.
  - len≠0: go to ISSUE with busy=1.
  - len=0: stay in IDLE; done pulses the next cycle; no beats; cmd_ready is 0 during that cycle.
- ISSUE:
  - Issue one read per cycle while credit = occupancy + inflight < FIFO_DEPTH.
  - An issue drives mem_chipselect=1 and mem_address=cur.
  - On issue, set cur = (cur==MEM_WORDS-1) ? 0 : cur+1 and decrement remaining.
  - After the issue with remaining==1, go to DRAIN.
- Return path:
  - mem_readdata is captured unconditionally into the FIFO on the cycle after each issue.
  - inflight is at most 1 per cycle.
  - The FIFO never overflows by construction; overflow is a verification assertion.
- Stream:
  - st_valid = FIFO non-empty.
  - st_sop on the first beat of the command.
  - st_eop on beat number cmd_len.
  - Beat data is unchanged while st_valid&!st_ready.
- DRAIN:
  - When the eop beat is accepted, done=1 for one cycle, busy=0, go to IDLE.
  - cmd_ready rises in the cycle after done.
- cmd_valid while busy is ignored and has no side effects.
- Width rules:
  - remaining is LEN_W bits.
  - cmd_len up to 2^LEN_W-1 is legal and may exceed MEM_WORDS; the address simply wraps.

## Timing
- Accept edge at cycle T:
  - First issue in cycle T+1.
  - Data captured at the end of T+2.
  - First st_valid in T+3.
- With st_ready held at 1 and FIFO_DEPTH≥3:
  - 1 beat/cycle.
  - Packet of N beats: last beat in T+2+N, done in T+3+N.
- st_ready low: issue halts once credit is exhausted; resumes the cycle after a beat is accepted.
- Reset values:
  - cmd_ready, busy, done, st_valid, st_sop, st_eop, mem_chipselect: 0.
  - mem_address and st_data: 0.
  - stall_cycles: 0.
  - Constant outputs keep their constant values.
  - cmd_ready becomes 1 on the first clk edge after reset_n deasserts.
- Reset mid-operation aborts immediately: FIFO and inflight are flushed, no done is produced, and the downstream sees a truncated packet.

## Configuration
- DIRCC_MEM_READER_STATS_EN defined:
  - stall_cycles increments on every cycle with st_valid&!st_ready.
  - Saturates at 0xFFFFFFFF.
  - Clears on reset and on each command accept.
- Undefined: stall_cycles is constant 0 and no counter logic is synthesized.

## Test plan
- Preload mem[0x100..0x103]=0xA0A0..0xA0A3, cmd addr=0x100 len=4, st_ready=1 -> beats A0A0..A0A3, sop on beat 1, eop on beat 4, first st_valid 3 cycles after accept, done 1 cycle after eop.
- cmd addr=20478 len=4 -> reads at addresses 20478, 20479, 0, 1 in that order.
- cmd len=0 -> done pulse in the next cycle, no st_valid, no mem_chipselect.
- len=16 with st_ready toggling 1/0 every cycle -> 16 beats in order, none dropped or duplicated, no FIFO overflow, stall_cycles=15 or 16 with STATS_EN (per last-beat phase), 0 without.
- reset_n low at beat 3 of a len=10 command -> all outputs at reset values within the same cycle; a new len=2 command then completes normally with sop/eop correct.
- cmd_valid held high throughout a len=8 command with changing cmd_addr -> exactly one command accepted; next accept occurs only after done.
